// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: single-cycle logic ops, add and sub,
// shift-add multiply, one request in flight, valid/ready on both sides.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   request handshake (in_ready high only in IDLE)
//   op, a, b             opcode and unsigned operands
//   out_valid, out_ready result handshake
//   result, err          registered result, illegal-opcode flag
//   busy                 high whenever the FSM is not in IDLE
module alu_sequencer #(
    parameter int DATA_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   result,
    output logic                  err,
    output logic                  busy
);

    localparam int RW = 2 * DATA_W;
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        DONE
    } state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [RW-1:0]     mcand;
    logic [RW-1:0]     acc;
    logic [CW-1:0]     cnt;

    logic [RW-1:0]     a_ext;
    logic [RW-1:0]     b_ext;
    logic [RW-1:0]     exec_res;
    logic              exec_err;
    logic [RW-1:0]     acc_next;

    always_comb begin
        a_ext    = RW'(a_q);
        b_ext    = RW'(b_q);
        exec_res = '0;
        exec_err = 1'b0;
        case (op_q)
            3'b000:  exec_res = a_ext & b_ext;
            3'b001:  exec_res = a_ext | b_ext;
            3'b010:  exec_res = a_ext ^ b_ext;
            3'b011:  exec_res = a_ext + b_ext;
            3'b100:  exec_res = a_ext - b_ext;
            default: exec_err = 1'b1;
        endcase
    end

    // b_q is consumed LSB first; mcand shifts left in step with it
    assign acc_next = b_q[0] ? acc + mcand : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mcand     <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= op;
                        a_q      <= a;
                        b_q      <= b;
                        mcand    <= RW'(a);
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (op == 3'b101) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    result    <= exec_res;
                    err       <= exec_err;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                MUL: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    b_q   <= b_q >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(DATA_W - 1)) begin
                        result    <= acc_next;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed cases plus random
// requests checked against an arithmetic reference model.
module tb_alu_sequencer;

    localparam int W = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           err;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2*W-1:0] res;
        logic           err;
    } exp_t;

    exp_t sb[$];

    alu_sequencer #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o,
                                   input int unsigned x,
                                   input int unsigned y);
        int unsigned r;
        exp_t e;
        e.err = 1'b0;
        case (o)
            3'd0:    r = x & y;
            3'd1:    r = x | y;
            3'd2:    r = x ^ y;
            3'd3:    r = x + y;
            3'd4:    r = x - y;
            3'd5:    r = x * y;
            default: begin r = 0; e.err = 1'b1; end
        endcase
        e.res = r[2*W-1:0];
        return e;
    endfunction

    // Monitor: compare whenever a result handshake is about to happen
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic run(input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int hold);
        int t;
        int lat;
        logic [2*W-1:0] r0;
        logic e0;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        out_ready = (hold == 0);
        sb.push_back(model(o, x, y));
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); a = W'($urandom); b = W'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_valid = 1'($urandom);
            op = 3'($urandom); a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1; lat++;
            if (!out_valid)
                check("busy_in_flight", 32'(busy), 32'd1);
        end
        check("latency", 32'(lat), (o == 3'd5) ? 32'(W) : 32'd1);
        r0 = result;
        e0 = err;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op = 3'($urandom); a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            check("hold_result", 32'(result), 32'(r0));
            check("hold_err", 32'(err), 32'(e0));
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        // in_valid stays high across the pop edge: it must not be taken
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("valid_after_pop", 32'(out_valid), 32'd0);
        check("in_ready_after_pop", 32'(in_ready), 32'd1);
        check("busy_after_pop", 32'(busy), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        op = 3'd0; a = 3'd1; b = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;

        run(3'b000, 3'b101, 3'b110, 0);
        run(3'b011, 3'd7, 3'd7, 0);
        run(3'b100, 3'd2, 3'd5, 1);
        run(3'b101, 3'd7, 3'd7, 0);
        run(3'b101, 3'd5, 3'd0, 2);
        run(3'b110, 3'd3, 3'd4, 0);
        run(3'b001, 3'd3, 3'd4, 0);
        run(3'b111, 3'd1, 3'd1, 1);
        run(3'b010, 3'd6, 3'd3, 5);

        for (int i = 0; i < 60; i++)
            run(3'($urandom), W'($urandom), W'($urandom),
                int'($urandom_range(0, 3)));

        // Reset during the second MUL cycle
        op = 3'b101; a = 3'd7; b = 3'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_result", 32'(result), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_busy", 32'(busy), 32'd0);
        run(3'b000, 3'b111, 3'b011, 0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 3, giving operand width; the result width SHALL be 2*DATA_W (6 at default).
REQ-002 clk  input  1  rising-edge clock; the block SHALL use a single clock domain.
REQ-003 rst  input  1  reset; the block SHALL treat rst as synchronous and active-high.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  sequencer can accept a request.
REQ-006 op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL, 110/111 illegal.
REQ-007 a  input  DATA_W  operand A, unsigned.
REQ-008 b  input  DATA_W  operand B, unsigned.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 result  output  2*DATA_W  registered result.
REQ-012 err  output  1  result belongs to an illegal opcode; valid only while out_valid=1.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC, MUL and DONE.
REQ-015 in_ready SHALL be 1 in IDLE only, and 0 in all other states.
REQ-016 On an edge where in_valid=1 and in_ready=1, the block SHALL latch op, a and b and go to EXEC for op 000-100 and 110-111, or to MUL for op 101.
REQ-017 Later changes to op, a or b SHALL NOT affect an accepted request.
REQ-018 EXEC SHALL last one cycle; it SHALL register the result zero-extended to 2*DATA_W, then go to DONE.
REQ-019 Single-cycle latency: with accept at edge k, out_valid SHALL be 1 after edge k+1.
REQ-020 Bitwise ops (AND, OR, XOR) SHALL operate per bit on DATA_W bits; upper DATA_W result bits SHALL be 0.
REQ-021 ADD SHALL give the unsigned sum a+b; at default width the maximum is 14, with no overflow.
REQ-022 SUB SHALL give a-b modulo 2^(2*DATA_W) (two's-complement wrap).
REQ-023 MUL SHALL run shift-add, one multiplier bit of b per cycle, LSB first, for exactly DATA_W cycles.
REQ-024 The accumulator SHALL be 2*DATA_W bits; after the last iteration the FSM SHALL go to DONE.
REQ-025 MUL latency: with accept at edge k, out_valid SHALL be 1 after edge k+DATA_W.
REQ-026 MUL with b=0 SHALL still take DATA_W cycles and give 0.
REQ-027 Illegal opcode: the block SHALL go through EXEC like a single-cycle op and give result=0 with err=1; err SHALL be 0 for all legal ops.
REQ-028 In DONE, out_valid SHALL be 1, and result and err SHALL stay stable until the handshake.
REQ-029 On an edge where out_valid=1 and out_ready=1, the block SHALL go to IDLE and clear out_valid.
REQ-030 in_ready SHALL rise in the cycle after the result pop; there SHALL be no same-cycle pop-and-accept.
REQ-031 out_ready=1 outside DONE SHALL have no effect.
REQ-032 in_valid=1 outside IDLE SHALL be ignored, with no queueing.
REQ-033 The block SHALL hold at most one request in flight.

Reset
REQ-034 When rst=1 at an edge, the FSM SHALL go to IDLE in any state, abandoning any EXEC, MUL or DONE contents.
REQ-035 After reset: out_valid=0, result=0, err=0, busy=0, in_ready=1.
REQ-036 If rst and in_valid are high on the same edge, reset SHALL win and the request SHALL NOT be accepted.
REQ-037 The first accept SHALL be possible on the first edge after rst is released.

Verification
REQ-038 Bitwise: AND a=101, b=110, out_ready=1 -> result=000100, err=0, out_valid high exactly 1 cycle after edge k+1.
REQ-039 Add/sub: ADD a=7, b=7 -> result=001110; SUB a=2, b=5 -> result=111101.
REQ-040 Multiply: MUL a=7, b=7 -> out_valid after edge k+3, result=110001 (49), busy=1 for 3 cycles before DONE; MUL a=5, b=0 -> result=0, still 3 cycles.
REQ-041 Back-pressure: out_ready=0 for 5 cycles after out_valid -> result and err stable, in_ready=0, in_valid with new operands ignored; pop -> IDLE, and the next request is accepted one cycle later.
REQ-042 Illegal op: op=110 -> result=000000, err=1; the next legal op clears err.
REQ-043 Reset: rst asserted during the 2nd MUL cycle -> next cycle IDLE, out_valid=0, result=0, in_ready=1; a new AND request completes correctly.
